// File: rtl/sram_1rw1r_gen_pkg.sv
// sram_gen_pkg: shared state type and lane-mask helpers for the sram_1rw1r_gen memory.
// Helpers work on MAX_WIDTH-bit vectors; callers size-cast to their own DATA_WIDTH.
package sram_gen_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } sram_state_t;

  localparam int MAX_WIDTH  = 256;
  localparam int LANE_IDX_W = $clog2(MAX_WIDTH);

  function automatic logic [MAX_WIDTH-1:0] expand_mask(input logic [MAX_WIDTH-1:0] wmask,
                                                       input int lane_size);
    logic [MAX_WIDTH-1:0]  bits;
    logic [LANE_IDX_W-1:0] lane;
    bits = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      lane    = LANE_IDX_W'(i / lane_size);
      bits[i] = wmask[lane];
    end
    return bits;
  endfunction

  // Bits set in mask take new_word; the rest keep old_word.
  function automatic logic [MAX_WIDTH-1:0] merge_lanes(input logic [MAX_WIDTH-1:0] old_word,
                                                       input logic [MAX_WIDTH-1:0] new_word,
                                                       input logic [MAX_WIDTH-1:0] mask);
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/sram_1rw1r_gen_if.sv
// sram_1rw1r_gen_if: request/response bundle for the 1RW port 0 and the read-only port 1.
interface sram_1rw1r_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int WMASK_SIZE = 8
);
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_SIZE;

  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  rvalid0;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  rvalid1;
  logic                  collision;
  logic                  ready;

  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  dout0, rvalid0, dout1, rvalid1, collision, ready
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output dout0, rvalid0, dout1, rvalid1, collision, ready
  );
endinterface

// File: rtl/sram_1rw1r_gen_rdpipe.sv
// sram_gen_rdpipe: one read-result register stage; data holds its last value while idle.
module sram_gen_rdpipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  d_valid,
  input  logic [DATA_WIDTH-1:0] d_data,
  input  logic                  d_flag,
  output logic                  q_valid,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic                  q_flag
);
  always_ff @(posedge clk0) begin
    if (rst0) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_flag  <= 1'b0;
    end else begin
      q_valid <= d_valid;
      q_flag  <= d_valid & d_flag;
      if (d_valid) q_data <= d_data;
    end
  end
endmodule

// File: rtl/sram_1rw1r_gen.sv
// sram_1rw1r_gen: parametrised 1RW+1R register-array memory with zero-fill sweep after reset,
// lane-masked writes, defined read-during-write result and optional output register stage.
module sram_1rw1r_gen
  import sram_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int WMASK_SIZE = 8,
  parameter int OUT_REG    = 0,
  parameter int BYPASS     = 1,
  parameter int INIT_ZERO  = 1
) (
`ifdef USE_POWER_PINS
  inout wire              vccd1,
  inout wire              vssd1,
`endif
  input logic             clk0,
  input logic             rst0,
  sram_1rw1r_gen_if.slave bus
);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NSTAGE = 2 + OUT_REG;

  if (DATA_WIDTH % WMASK_SIZE != 0) begin : g_bad_mask
    $error("DATA_WIDTH must be an integer multiple of WMASK_SIZE");
  end
  if (DATA_WIDTH > MAX_WIDTH) begin : g_too_wide
    $error("DATA_WIDTH exceeds MAX_WIDTH of sram_gen_pkg");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  sram_state_t           state, state_next;
  logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_next;
  logic                  init_we;
  logic                  accept, wr_en, rd0_en, rd1_en, hit;
  logic [DATA_WIDTH-1:0] bit_mask, wr_word, rd1_word;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    init_we       = 1'b0;
    case (state)
      ST_INIT: begin
        if (INIT_ZERO != 0) begin
          init_we       = 1'b1;
          init_cnt_next = init_cnt + 1'b1;
          if (&init_cnt) state_next = ST_READY;
        end else begin
          state_next = ST_READY;
        end
      end
      default: ;
    endcase
  end

  // Requests only count when the sweep is done and reset is not being applied this edge.
  assign accept    = (state == ST_READY) && !rst0;
  assign wr_en     = accept && !bus.csb0 && !bus.web0;
  assign rd0_en    = accept && !bus.csb0 && bus.web0;
  assign rd1_en    = accept && !bus.csb1;
  assign hit       = wr_en && rd1_en && (bus.addr0 == bus.addr1);
  assign bus.ready = (state == ST_READY);

  assign bit_mask = DATA_WIDTH'(expand_mask(MAX_WIDTH'(bus.wmask0), WMASK_SIZE));
  assign wr_word  = DATA_WIDTH'(merge_lanes(MAX_WIDTH'(mem[bus.addr0]), MAX_WIDTH'(bus.din0),
                                            MAX_WIDTH'(bit_mask)));

  // On a hit, wr_word is already the old word with the written lanes merged in.
  always_comb begin
    rd1_word = mem[bus.addr1];
    if (BYPASS != 0 && hit) rd1_word = wr_word;
  end

  always_ff @(posedge clk0) begin
    if (!rst0) begin
      if (init_we) mem[init_cnt] <= '0;
      else if (wr_en) mem[bus.addr0] <= wr_word;
    end
  end

  logic [DATA_WIDTH-1:0] p0_data [NSTAGE+1];
  logic [DATA_WIDTH-1:0] p1_data [NSTAGE+1];
  logic [NSTAGE:0]       p0_valid, p0_flag, p1_valid, p1_flag;
  logic                  unused_p0_flag;

  assign p0_data[0]  = mem[bus.addr0];
  assign p0_valid[0] = rd0_en;
  assign p0_flag[0]  = 1'b0;
  assign p1_data[0]  = rd1_word;
  assign p1_valid[0] = rd1_en;
  assign p1_flag[0]  = hit;

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    sram_gen_rdpipe #(.DATA_WIDTH(DATA_WIDTH)) u_port0 (
      .clk0(clk0), .rst0(rst0),
      .d_valid(p0_valid[s]), .d_data(p0_data[s]), .d_flag(p0_flag[s]),
      .q_valid(p0_valid[s+1]), .q_data(p0_data[s+1]), .q_flag(p0_flag[s+1])
    );
    sram_gen_rdpipe #(.DATA_WIDTH(DATA_WIDTH)) u_port1 (
      .clk0(clk0), .rst0(rst0),
      .d_valid(p1_valid[s]), .d_data(p1_data[s]), .d_flag(p1_flag[s]),
      .q_valid(p1_valid[s+1]), .q_data(p1_data[s+1]), .q_flag(p1_flag[s+1])
    );
  end

  assign bus.dout0       = p0_data[NSTAGE];
  assign bus.rvalid0     = p0_valid[NSTAGE];
  assign bus.dout1       = p1_data[NSTAGE];
  assign bus.rvalid1     = p1_valid[NSTAGE];
  assign bus.collision   = p1_flag[NSTAGE];
  assign unused_p0_flag  = p0_flag[NSTAGE];

endmodule
